// File: rtl/duty_button_conditioner.sv
// duty_button_conditioner: debounced duty up/down buttons to interlocked single-cycle command pulses with auto-repeat; ports clk, reset, btn_up_raw, btn_down_raw -> increase_duty, decrease_duty, up_level, down_level
module duty_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN = 1,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 20000000,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic increase_duty,
  output logic decrease_duty,
  output logic up_level,
  output logic down_level
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;
  localparam state_t PRESSED = (REPEAT_EN != 0) ? DELAY : HELD;
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXV = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam logic [CNT_W-1:0] DB_N = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RD_N = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_N = CNT_W'(REPEAT_PERIOD);
  logic [1:0] raw, level, pulse;
  logic conflict, conflict_d;
  assign raw = {btn_down_raw, btn_up_raw};
  assign conflict = &level;
  assign {decrease_duty, increase_duty} = pulse;
  assign {down_level, up_level} = level;
  always_ff @(posedge clk) conflict_d <= reset ? 1'b0 : conflict;
  always_ff @(posedge clk) assert (CNT_W >= $clog2(MAXV + 1)) else $error("CNT_W too narrow for configured counts");
  genvar c;
  for (c = 0; c < 2; c++) begin : g_ch
    logic [1:0] sync;
    logic [CNT_W-1:0] dcnt, dinc, rcnt, rinc, rcnt_n;
    logic lvl, p, pulse_n, dhit;
    state_t state, state_n;
    // saturating increments: counters never wrap
    assign dinc = dcnt + CNT_W'(~&dcnt);
    assign rinc = rcnt + CNT_W'(~&rcnt);
    assign dhit = dinc >= DB_N;
    assign level[c] = lvl;
    assign pulse[c] = p;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync <= '0;
        dcnt <= '0;
        lvl <= 1'b0;
      end else begin
        sync <= {sync[0], raw[c]};
        dcnt <= (sync[1] == lvl || dhit) ? '0 : dinc;
        lvl <= lvl ^ (sync[1] != lvl && dhit);
      end
    end
    // conflict freezes the state; the first clean cycle after it resumes a held button in DELAY, already counting that cycle
    always_comb begin
      state_n = state;
      rcnt_n = rcnt;
      pulse_n = 1'b0;
      if (!lvl) begin
        state_n = IDLE;
        rcnt_n = '0;
      end else if (conflict) begin
        rcnt_n = '0;
      end else if (conflict_d) begin
        state_n = PRESSED;
        rcnt_n = CNT_W'(1);
      end else begin
        case (state)
          IDLE: begin
            state_n = PRESSED;
            rcnt_n = '0;
            pulse_n = 1'b1;
          end
          DELAY: begin
            pulse_n = rinc >= RD_N;
            state_n = pulse_n ? REPEAT : DELAY;
            rcnt_n = pulse_n ? '0 : rinc;
          end
          REPEAT: begin
            pulse_n = rinc >= RP_N;
            rcnt_n = pulse_n ? '0 : rinc;
          end
          default: ;
        endcase
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        rcnt <= '0;
        p <= 1'b0;
      end else begin
        state <= state_n;
        rcnt <= rcnt_n;
        p <= pulse_n;
      end
    end
  end
endmodule

// File: tb/tb_duty_button_conditioner.sv
// tb_duty_button_conditioner: directed vector and sequence checks of the button conditioner
module tb_duty_button_conditioner;
  logic clk = 1'b0;
  logic rst, up, dn;
  logic inc, dec, upl, dnl, inc0, dec0, upl0, dnl0;
  int cyc = 0, checks = 0, errors = 0, both = 0;
  int inc_t[$], dec_t[$], inc0_t[$], dec0_t[$], got[$], exp_t[$];
  typedef struct {logic rst, up, dn, inc, dec, upl, dnl;} vec_t;
  vec_t tbl[11];
  always #5 clk = ~clk;
  duty_button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(8)) dut (
    .clk(clk), .reset(rst), .btn_up_raw(up), .btn_down_raw(dn),
    .increase_duty(inc), .decrease_duty(dec), .up_level(upl), .down_level(dnl));
  duty_button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(8)) dut0 (
    .clk(clk), .reset(rst), .btn_up_raw(up), .btn_down_raw(dn),
    .increase_duty(inc0), .decrease_duty(dec0), .up_level(upl0), .down_level(dnl0));
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (inc) inc_t.push_back(cyc);
    if (dec) dec_t.push_back(cyc);
    if (inc0) inc0_t.push_back(cyc);
    if (dec0) dec0_t.push_back(cyc);
    if ((inc && dec) || (inc0 && dec0)) both++;
  endtask
  task automatic run_to(int t);
    while (cyc < t) step();
  endtask
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic check_times(string name);
    string gs = "", es = "";
    bit ok;
    checks++;
    ok = got.size() == exp_t.size();
    for (int i = 0; i < got.size(); i++) begin
      gs = $sformatf("%s %0d", gs, got[i]);
      if (ok && got[i] != exp_t[i]) ok = 0;
    end
    for (int i = 0; i < exp_t.size(); i++) es = $sformatf("%s %0d", es, exp_t[i]);
    if (!ok) begin
      errors++;
      $display("FAIL %s: pulse cycles got [%s ] expected [%s ]", name, gs, es);
    end
    exp_t.delete();
  endtask
  task automatic clear_logs();
    inc_t.delete();
    dec_t.delete();
    inc0_t.delete();
    dec0_t.delete();
  endtask
  initial begin
    int s;
    bit bounce_bad;
    rst = 1'b1;
    up = 1'b0;
    dn = 1'b0;
    for (int i = 0; i < 11; i++) tbl[i] = '{i < 3, 1'b1, 1'b0, 1'b0, 1'b0, i >= 8, 1'b0};
    tbl[9].inc = 1'b1;
    // reset with up held, then first press: level after edge E0+5, pulse after E0+6 (cycle 10)
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      up = tbl[i].up;
      dn = tbl[i].dn;
      step();
      check($sformatf("t1_inc[%0d]", i), inc, tbl[i].inc);
      check($sformatf("t1_dec[%0d]", i), dec, tbl[i].dec);
      check($sformatf("t1_upl[%0d]", i), upl, tbl[i].upl);
      check($sformatf("t1_dnl[%0d]", i), dnl, tbl[i].dnl);
      check($sformatf("t1_upl0[%0d]", i), upl0, tbl[i].upl);
    end
    // continued hold: repeats at P+20 then every 8; release before edge 63
    run_to(62);
    up = 1'b0;
    run_to(67);
    check("t3_upl_before_drop", upl, 1);
    step();
    check("t3_upl_drop", upl, 0);
    run_to(97);
    got = inc_t;
    exp_t = '{10, 30, 38, 46, 54, 62};
    check_times("t3_inc_repeat");
    got = inc0_t;
    exp_t = '{10};
    check_times("t3_inc_norepeat");
    got = dec_t;
    check_times("t3_dec_none");
    clear_logs();
    // bouncing down button, then stable press
    bounce_bad = 0;
    for (int k = 0; k < 10; k++) begin
      dn = 1'b1;
      step();
      bounce_bad |= dnl;
      step();
      bounce_bad |= dnl;
      dn = 1'b0;
      step();
      bounce_bad |= dnl;
      step();
      bounce_bad |= dnl;
    end
    check("t2_bounce_level", bounce_bad, 0);
    dn = 1'b1;
    s = cyc + 1;
    run_to(s + 10);
    got = dec_t;
    exp_t = '{s + 6};
    check_times("t2_dec_pulse");
    got = dec0_t;
    exp_t = '{s + 6};
    check_times("t2_dec0_pulse");
    got = inc_t;
    check_times("t2_inc_none");
    dn = 1'b0;
    run_to(cyc + 10);
    check("t2_dnl_released", dnl, 0);
    clear_logs();
    // long hold without auto-repeat
    up = 1'b1;
    s = cyc + 1;
    run_to(s + 99);
    got = inc0_t;
    exp_t = '{s + 6};
    check_times("t4_single_pulse");
    up = 1'b0;
    run_to(cyc + 10);
    clear_logs();
    // interlock: down pressed while up held in DELAY
    up = 1'b1;
    s = cyc + 1;
    run_to(s + 14);
    dn = 1'b1;
    run_to(s + 44);
    dn = 1'b0;
    run_to(s + 49);
    check("t5_dnl_held", dnl, 1);
    step();
    check("t5_dnl_drop", dnl, 0);
    run_to(s + 75);
    got = inc_t;
    exp_t = '{s + 6, s + 70};
    check_times("t5_inc_resume");
    got = dec_t;
    check_times("t5_dec_none");
    got = inc0_t;
    exp_t = '{s + 6};
    check_times("t5_inc0_once");
    got = dec0_t;
    check_times("t5_dec0_none");
    up = 1'b0;
    run_to(cyc + 10);
    clear_logs();
    // reset in REPEAT mid-hold, then re-debounce and restart repeat timing
    up = 1'b1;
    s = cyc + 1;
    run_to(s + 36);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t6_reset_outs[%0d]", k), {inc, dec, upl, dnl, inc0, dec0, upl0, dnl0}, 0);
    end
    rst = 1'b0;
    run_to(s + 76);
    got = inc_t;
    exp_t = '{s + 6, s + 26, s + 34, s + 46, s + 66, s + 74};
    check_times("t6_inc_restart");
    up = 1'b0;
    run_to(cyc + 10);
    check("both_high_cycles", both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
